// File: rtl/psm_pkg.sv
// Shared types for the PSM preload path: the preload sequencer state encoding.
package psm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } psm_preload_state_t;

endpackage

// File: rtl/psm_sync_fifo.sv
// Single-clock FIFO of full Y-row partial-sum words with occupancy-derived flags,
// almost-full backpressure and a sticky overflow indicator.
module psm_sync_fifo #(
    parameter int BUFF_W    = 144,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 3
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_push,
    input  logic [BUFF_W-1:0] i_din,
    input  logic              i_pop,
    input  logic              i_clear,
    output logic [BUFF_W-1:0] o_head,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BUFF_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_ok;

    assign o_empty       = (count_q == '0);
    assign o_full        = (count_q == CNT_W'(DEPTH));
    assign o_almost_full = ((32'(DEPTH) - 32'(count_q)) <= 32'(AF_MARGIN));
    assign o_overflow    = overflow_q;
    assign o_head        = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = i_push && (!o_full || i_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (i_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (i_pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !i_pop)      count_d = count_q + CNT_W'(1);
            else if (!push_ok && i_pop) count_d = count_q - CNT_W'(1);
            if (i_push && !push_ok) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_clear) mem_q[wr_ptr_q] <= i_din;
    end

endmodule

// File: rtl/psm_preload_fifo.sv
// Buffers partial-sum rows from the PSM read-data manager and replays X of them
// per preload context into the systolic array's psum preload chain.
module psm_preload_fifo
    import psm_pkg::*;
#(
    parameter int BUFF_W    = 144,
    parameter int DEPTH     = 4,
    parameter int X         = 3,
    parameter int AF_MARGIN = 3
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_fifo_push,
    input  logic [BUFF_W-1:0] i_fifo_din,
    input  logic              i_clearbuff,
    input  logic              i_preload_start,
    input  logic              i_stall,
    output logic              o_shift_en,
    output logic [BUFF_W-1:0] o_psum_data,
    output logic              o_preload_done,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_overflow
);

    localparam int COL_W = (X > 1) ? $clog2(X) : 1;

    psm_preload_state_t state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [BUFF_W-1:0]  head_data;
    logic               pop;

    assign pop = (state_q == SHIFT) && !o_empty && !i_stall && !i_clearbuff;

    psm_sync_fifo #(
        .BUFF_W    (BUFF_W),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_fifo (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_push        (i_fifo_push),
        .i_din         (i_fifo_din),
        .i_pop         (pop),
        .i_clear       (i_clearbuff),
        .o_head        (head_data),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        if (i_clearbuff) begin
            state_d = IDLE;
            col_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_preload_start) begin
                        state_d = SHIFT;
                        col_d   = '0;
                    end
                end
                SHIFT: begin
                    if (pop) begin
                        if (col_q == COL_W'(X - 1)) begin
                            state_d = DONE;
                            col_d   = '0;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // The array samples the head on the pop edge, so it is only exposed while popping.
    assign o_shift_en     = pop;
    assign o_psum_data    = pop ? head_data : '0;
    assign o_preload_done = (state_q == DONE);

endmodule
